// File: rtl/stim_check_pkg.sv
// rtl/stim_check_pkg.sv - shared types, widths and table helper for the stimulus/response checker
package stim_check_pkg;

  localparam int STIM_W = 4;
  localparam int RESP_W = 2;
  localparam int ERR_W  = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Pull the 2-bit expected response for vector idx out of the packed table.
  function automatic logic [RESP_W-1:0] exp_entry(input logic [31:0] tbl,
                                                 input logic [STIM_W-1:0] idx);
    logic [31:0] shifted;
    shifted = tbl >> {idx, 1'b0};
    return shifted[RESP_W-1:0];
  endfunction

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable up-counter with clear and terminal count at SETTLE-1
module settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  output logic [3:0] cnt_o,
  output logic       tc_o
);

  localparam logic [3:0] TC_VAL = 4'(SETTLE - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Clear beats load, load beats count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == TC_VAL);

endmodule

// File: rtl/stim_response_checker.sv
// rtl/stim_response_checker.sv - walks stimulus vectors, samples responses, tallies mismatches
module stim_response_checker
  import stim_check_pkg::*;
#(
  parameter int          SETTLE    = 2,
  parameter int          VEC_COUNT = 16,
  parameter logic [31:0] EXP_TABLE = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [STIM_W-1:0] stim_out,
  input  logic [RESP_W-1:0] resp_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              first_fail_valid,
  output logic [STIM_W-1:0] first_fail_vec
);

  localparam logic [STIM_W-1:0] LAST_VEC = STIM_W'(VEC_COUNT - 1);

  state_e            state_q, state_d;
  logic [STIM_W-1:0] stim_q, stim_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              pass_q, pass_d;
  logic              ffv_q, ffv_d;
  logic [STIM_W-1:0] ffvec_q, ffvec_d;

  logic              accept;
  logic              mismatch;
  logic              last_vec;
  logic              timer_clr;
  logic              timer_en;
  logic              timer_tc;
  logic [3:0]        timer_cnt;

  assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign mismatch = (resp_in != exp_entry(EXP_TABLE, stim_q));
  assign last_vec = (stim_q == LAST_VEC);

  // The settle counter restarts on every accepted start and on every settle expiry.
  assign timer_en  = (state_q == S_SETTLE);
  assign timer_clr = accept || (timer_en && timer_tc);

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (timer_clr),
    .load_i     (1'b0),
    .load_val_i (4'd0),
    .en_i       (timer_en),
    .cnt_o      (timer_cnt),
    .tc_o       (timer_tc)
  );

  // State register; reset wins over any run in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_SETTLE;
      S_SETTLE:       if (timer_tc) state_d = S_SAMPLE;
      S_SAMPLE:       state_d = last_vec ? S_DONE : S_SETTLE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Result and stimulus next values: clear on accepted start, update only in SAMPLE.
  always_comb begin
    stim_d  = stim_q;
    err_d   = err_q;
    pass_d  = pass_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    if (accept) begin
      stim_d  = '0;
      err_d   = '0;
      pass_d  = 1'b0;
      ffv_d   = 1'b0;
      ffvec_d = '0;
    end else if (state_q == S_SAMPLE) begin
      if (mismatch) begin
        err_d = err_q + ERR_W'(1);
        if (!ffv_q) begin
          ffv_d   = 1'b1;
          ffvec_d = stim_q;
        end
      end
      if (last_vec) begin
        pass_d = (err_q == '0) && !mismatch;
      end else begin
        stim_d = stim_q + STIM_W'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stim_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else begin
      stim_q  <= stim_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end

  // Status flags decode directly from the state.
  always_comb begin
    busy = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    done = (state_q == S_DONE);
  end

  assign stim_out         = stim_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_stim_response_checker.sv
// tb/tb_stim_response_checker.sv - directed bench for stim_response_checker
module tb_stim_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic       start3;
  logic [1:0] resp0;

  logic [3:0] stim0, stim1, stim2, stim3;
  logic       busy0, busy1, busy2, busy3;
  logic       done0, done1, done2, done3;
  logic       pass0, pass1, pass2, pass3;
  logic [4:0] err0, err1, err2, err3;
  logic       ffv0, ffv1, ffv2, ffv3;
  logic [3:0] ffvec0, ffvec1, ffvec2, ffvec3;

  logic [1:0] resp1, resp2;
  assign resp1 = stim1[1:0];
  assign resp2 = stim2[1:0];

  int n_tests = 0;
  int n_fail  = 0;

  stim_response_checker u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stim_out(stim0), .resp_in(resp0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_valid(ffv0), .first_fail_vec(ffvec0)
  );

  stim_response_checker #(.EXP_TABLE(32'hE4E4E4E4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stim_out(stim1), .resp_in(resp1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
  );

  stim_response_checker #(.EXP_TABLE(32'hE4E4E4E5)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stim_out(stim2), .resp_in(resp2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail_valid(ffv2), .first_fail_vec(ffvec2)
  );

  stim_response_checker #(.SETTLE(1), .VEC_COUNT(4)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .stim_out(stim3), .resp_in(2'b11),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_fail_valid(ffv3), .first_fail_vec(ffvec3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_u0(input string tag);
    check({tag, " stim"},  32'(stim0),  32'h0);
    check({tag, " busy"},  32'(busy0),  32'h0);
    check({tag, " done"},  32'(done0),  32'h0);
    check({tag, " pass"},  32'(pass0),  32'h0);
    check({tag, " err"},   32'(err0),   32'h0);
    check({tag, " ffv"},   32'(ffv0),   32'h0);
    check({tag, " ffvec"}, 32'(ffvec0), 32'h0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    start3 = 1'b0;
    resp0  = 2'b00;
    step();
    step();
    check_zero_u0("reset");
    rst_n = 1'b1;
    step();

    // Run 1: clean run on u0, loopback runs on u1/u2, short stuck run on u3.
    start  = 1'b1;
    start3 = 1'b1;
    step();                       // edge 0
    start  = 1'b0;
    start3 = 1'b0;
    check("r1 busy after edge0", 32'(busy0), 32'h1);
    check("r1 stim after edge0", 32'(stim0), 32'h0);
    repeat (7) step();            // edge 7
    check("u3 done at edge7", 32'(done3), 32'h0);
    step();                       // edge 8
    check("u3 done at edge8", 32'(done3), 32'h1);
    check("u3 busy at edge8", 32'(busy3), 32'h0);
    check("u3 err",           32'(err3),  32'd4);
    check("u3 ffv",           32'(ffv3),  32'h1);
    check("u3 ffvec",         32'(ffvec3), 32'h0);
    check("u3 pass",          32'(pass3), 32'h0);
    check("u3 stim last",     32'(stim3), 32'h3);
    repeat (39) step();           // edge 47
    check("r1 done at edge47", 32'(done0), 32'h0);
    check("r1 busy at edge47", 32'(busy0), 32'h1);
    step();                       // edge 48
    check("r1 done at edge48", 32'(done0), 32'h1);
    check("r1 busy at edge48", 32'(busy0), 32'h0);
    check("r1 pass",  32'(pass0),  32'h1);
    check("r1 err",   32'(err0),   32'h0);
    check("r1 ffv",   32'(ffv0),   32'h0);
    check("r1 stim",  32'(stim0),  32'hF);
    check("u1 done",  32'(done1),  32'h1);
    check("u1 pass",  32'(pass1),  32'h1);
    check("u1 err",   32'(err1),   32'h0);
    check("u2 done",  32'(done2),  32'h1);
    check("u2 err",   32'(err2),   32'd1);
    check("u2 ffv",   32'(ffv2),   32'h1);
    check("u2 ffvec", 32'(ffvec2), 32'h0);
    check("u2 pass",  32'(pass2),  32'h0);
    repeat (3) step();
    check("r1 done holds", 32'(done0), 32'h1);
    check("r1 stim holds", 32'(stim0), 32'hF);
    check("r1 pass holds", 32'(pass0), 32'h1);

    // Run 2: stuck-at-11 response, extra start pulses while busy.
    resp0 = 2'b11;
    start = 1'b1;
    step();                       // edge 0
    check("r2 clears done", 32'(done0), 32'h0);
    check("r2 clears pass", 32'(pass0), 32'h0);
    start = 1'b1;                 // sampled at edge 1, in SETTLE
    step();                       // edge 1
    start = 1'b0;
    step();                       // edge 2
    start = 1'b1;                 // sampled at edge 3, in SAMPLE
    step();                       // edge 3
    start = 1'b0;
    check("r2 stim at edge3", 32'(stim0), 32'h1);
    repeat (41) step();           // edge 44
    start = 1'b1;                 // sampled at edge 45, in SAMPLE
    step();                       // edge 45
    start = 1'b0;
    step();                       // edge 46
    step();                       // edge 47
    check("r2 done at edge47", 32'(done0), 32'h0);
    step();                       // edge 48
    check("r2 done at edge48", 32'(done0), 32'h1);
    check("r2 err",   32'(err0),   32'd16);
    check("r2 ffv",   32'(ffv0),   32'h1);
    check("r2 ffvec", 32'(ffvec0), 32'h0);
    check("r2 pass",  32'(pass0),  32'h0);
    check("r2 u1 pass", 32'(pass1), 32'h1);
    check("r2 u2 err",  32'(err2),  32'd1);

    // Run 3: reset mid-run at vector 5, then a fresh clean run.
    resp0 = 2'b00;
    start = 1'b1;
    step();                       // edge 0
    start = 1'b0;
    repeat (15) step();           // edge 15
    check("r3 stim at edge15", 32'(stim0), 32'h5);
    rst_n = 1'b0;
    step();
    check_zero_u0("midrun reset");
    rst_n = 1'b1;
    step();
    start = 1'b1;
    step();                       // edge 0
    start = 1'b0;
    repeat (47) step();           // edge 47
    check("r4 done at edge47", 32'(done0), 32'h0);
    step();                       // edge 48
    check("r4 done at edge48", 32'(done0), 32'h1);
    check("r4 pass", 32'(pass0), 32'h1);
    check("r4 err",  32'(err0),  32'h0);
    check("r4 ffv",  32'(ffv0),  32'h0);
    check("r4 stim", 32'(stim0), 32'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stim_response_checker.md
Name: stim_response_checker

Overview:
- Synthesizable driver/checker that sits on the opposite side of the 4-input/2-output practice logic block: it drives the A..D inputs and checks the E,F outputs.
- On `start`, it walks a 4-bit stimulus through vectors 0..VEC_COUNT-1 and holds each vector for SETTLE cycles.
- It then samples the 2-bit response and compares it with a parameterised expected-value table.
- It reports the error count, the first failing vector, pass/fail and done; it replaces hand-written initial-block stimulus in on-chip self-check.

Parameters:
- SETTLE, 2: cycles each vector is held before sampling; legal range 1..15.
- VEC_COUNT, 16: number of vectors applied, starting at 0; legal range 1..16.
- EXP_TABLE, 32'h0000_0000: expected responses; entry i is EXP_TABLE[2*i+1:2*i], with bit 1 = expected E and bit 0 = expected F.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a run; ignored while busy=1.
- stim_out  output  4  vector driven to the DUT: [3]=A, [2]=B, [1]=C, [0]=D.
- resp_in  input  2  DUT response: [1]=E, [0]=F.
- busy  output  1  high from the cycle after start is accepted until done rises.
- done  output  1  high once the run completes; holds until the next accepted start or reset.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  5  number of mismatching vectors in the current run.
- first_fail_valid  output  1  set at the first mismatch of the run.
- first_fail_vec  output  4  stimulus value at the first mismatch.

Behaviour:
- Reset: applies on a rising clk edge with rst_n=0 and has priority over everything, including mid-run.
  - State returns to IDLE.
  - stim_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE or DONE, start=1:
  - stim_out<=0, settle_cnt<=0, err_count<=0, first_fail_valid<=0, first_fail_vec<=0.
  - done<=0, pass<=0, busy<=1; next state SETTLE.
- start=1 in SETTLE or SAMPLE: ignored; no effect on the run.
- SETTLE: settle_cnt increments each cycle. When settle_cnt==SETTLE-1, settle_cnt<=0 and the state moves to SAMPLE. stim_out is stable throughout.
- SAMPLE (exactly one cycle): resp_in is compared with entry stim_out.
  - On mismatch: err_count increments. If first_fail_valid==0, set first_fail_valid<=1 and first_fail_vec<=stim_out.
  - If stim_out==VEC_COUNT-1: next state DONE, busy<=0, done<=1, pass<=(no mismatch in the run, including this one).
  - Otherwise: stim_out<=stim_out+1 and next state SETTLE.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - With start sampled at edge k, done is high after edge k+VEC_COUNT*(SETTLE+1).
  - resp_in is sampled SETTLE+1 edges after stim_out changes.
- Width rules: err_count maximum is 16, so it never saturates. stim_out never exceeds VEC_COUNT-1 and never wraps within a run.
- DONE holds all result outputs stable. stim_out keeps the last vector until the next start.

Decomposition:
- Shared package (stim_check_pkg):
  - State encoding: IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3.
  - Constants: STIM_W=4, RESP_W=2, ERR_W=5.
  - Expected-entry extraction function exp_entry(table, idx).
- One natural sub-module, settle_timer: loadable up-counter with clear and terminal-count output, parameterised by SETTLE. The FSM and result registers stay in the top.

Test Plan:
- Default parameters, resp_in tied to 2'b00, start pulse at edge 0:
  - busy rises after edge 0; done=1 after edge 48.
  - pass=1, err_count=0, first_fail_valid=0, stim_out=4'hF.
- EXP_TABLE=32'hE4E4E4E4, resp_in=stim_out[1:0] loopback: pass=1, err_count=0.
- Same loopback with EXP_TABLE=32'hE4E4E4E5 (entry 0 expects 01): err_count=1, first_fail_valid=1, first_fail_vec=0, pass=0.
- resp_in stuck at 2'b11, default table:
  - VEC_COUNT=16: err_count=16, first_fail_vec=0.
  - VEC_COUNT=4, SETTLE=1: err_count=4, done after edge 8.
- Start pulses during SETTLE and SAMPLE mid-run: the run is unaffected; the count and timing match the single-start case.
- rst_n=0 for one edge while stim_out=5: all outputs read zero after that edge. A fresh start then completes a clean 48-cycle run with correct results.
